// File: rtl/local_store_dp.sv
// local_store_dp: line-wide scratch memory shared by the load/store unit and
// the DMA engine. One access per cycle, DMA-first arbitration with a
// starvation guard for LS, registered one-cycle reads, per-byte LS write
// masks and a counter-driven clear sequence after reset.
module local_store_dp #(
    parameter int ADDR_W     = 15,
    parameter int LINE_BYTES = 16,
    parameter int INIT_CLEAR = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      init_busy,
    input  logic                      ls_req,
    input  logic                      ls_we,
    input  logic [0:ADDR_W-1]         ls_addr,
    input  logic [0:8*LINE_BYTES-1]   ls_wdata,
    input  logic [0:LINE_BYTES-1]     ls_bmask,
    output logic                      ls_gnt,
    output logic [0:8*LINE_BYTES-1]   ls_rdata,
    output logic                      ls_rvalid,
    input  logic                      dma_req,
    input  logic                      dma_we,
    input  logic [0:ADDR_W-1]         dma_addr,
    input  logic [0:8*LINE_BYTES-1]   dma_wdata,
    output logic                      dma_gnt,
    output logic [0:8*LINE_BYTES-1]   dma_rdata,
    output logic                      dma_rvalid
);
    localparam int DW     = 8 * LINE_BYTES;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int NLINES = 1 << LINE_W;
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [LINE_W-1:0]   clr_cnt;
    logic [CNT_W-1:0]    starve_cnt;
    logic                run;
    logic                force_ls;

    logic [0:DW-1]       mem [0:NLINES-1];

    // Addresses are copied into descending vectors so the line index is the
    // numerically upper part; the byte offset within a line is ignored.
    logic [ADDR_W-1:0]   ls_a;
    logic [ADDR_W-1:0]   dma_a;
    logic [LINE_W-1:0]   ls_idx;
    logic [LINE_W-1:0]   dma_idx;
    logic                unused_offset_bits;

    assign ls_a    = ls_addr;
    assign dma_a   = dma_addr;
    assign ls_idx  = ls_a[ADDR_W-1:OFF_W];
    assign dma_idx = dma_a[ADDR_W-1:OFF_W];
    assign unused_offset_bits = ^{ls_a[OFF_W-1:0], dma_a[OFF_W-1:0]};

    // Single shared write port into the array.
    logic                wr_en;
    logic [LINE_W-1:0]   wr_idx;
    logic [0:DW-1]       wr_data;
    logic [0:LINE_BYTES-1] wr_be;

    assign init_busy = (state == ST_INIT);

    // State register: reset chooses between the clear sequence and running.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave INIT once the last line has been cleared.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (clr_cnt == {LINE_W{1'b1}}) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // Clear counter walks every line once while in INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == ST_INIT) begin
            clr_cnt <= clr_cnt + LINE_W'(1);
        end
    end

    // Arbitration: DMA first, unless LS has been denied STARVE_MAX times.
    always_comb begin
        run      = !rst && (state == ST_RUN);
        force_ls = ls_req && (starve_cnt == CNT_W'(STARVE_MAX));
        dma_gnt  = run && dma_req && !force_ls;
        ls_gnt   = run && ls_req && !(dma_req && !force_ls);
    end

    // Starvation counter: counts consecutive cycles LS waits behind DMA.
    always_ff @(posedge clk) begin
        if (rst || !ls_req || ls_gnt) begin
            starve_cnt <= '0;
        end else if (dma_gnt && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Write-port mux: clear line, DMA full-line write, or masked LS write.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = clr_cnt;
        wr_data = '0;
        wr_be   = '1;
        if (!rst) begin
            if (state == ST_INIT) begin
                wr_en = 1'b1;
            end else if (dma_gnt && dma_we) begin
                wr_en   = 1'b1;
                wr_idx  = dma_idx;
                wr_data = dma_wdata;
            end else if (ls_gnt && ls_we) begin
                wr_en   = 1'b1;
                wr_idx  = ls_idx;
                wr_data = ls_wdata;
                wr_be   = ls_bmask;
            end
        end
    end

    // Array write with per-byte enables; byte k occupies bits [8k:8k+7].
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < LINE_BYTES; k++) begin
                if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    // LS read register: latch on a granted read, pulse rvalid next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            ls_rvalid <= ls_gnt && !ls_we;
            if (ls_gnt && !ls_we) ls_rdata <= mem[ls_idx];
        end
    end

    // DMA read register: same behaviour as the LS side.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_gnt && !dma_we;
            if (dma_gnt && !dma_we) dma_rdata <= mem[dma_idx];
        end
    end

endmodule

// File: tb/tb_local_store_dp.sv
// Bench for local_store_dp: a byte-array reference model predicts grants and
// read data; expected reads go into per-port queues that a monitor drains
// whenever the DUT raises rvalid.
module tb_local_store_dp;
    localparam int ADDR_W = 15;
    localparam int LB     = 16;
    localparam int DW     = 128;
    localparam int NLINES = 2048;
    localparam int SMAX   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              init_busy;
    logic              ls_req = 1'b0, ls_we = 1'b0;
    logic [0:ADDR_W-1] ls_addr = '0;
    logic [0:DW-1]     ls_wdata = '0;
    logic [0:LB-1]     ls_bmask = '0;
    logic              ls_gnt, ls_rvalid;
    logic [0:DW-1]     ls_rdata;
    logic              dma_req = 1'b0, dma_we = 1'b0;
    logic [0:ADDR_W-1] dma_addr = '0;
    logic [0:DW-1]     dma_wdata = '0;
    logic              dma_gnt, dma_rvalid;
    logic [0:DW-1]     dma_rdata;

    local_store_dp #(.ADDR_W(ADDR_W), .LINE_BYTES(LB), .INIT_CLEAR(1), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .init_busy(init_busy),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_bmask(ls_bmask), .ls_gnt(ls_gnt), .ls_rdata(ls_rdata), .ls_rvalid(ls_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid)
    );

    // Second instance without the clear sequence.
    logic          b_rst = 1'b1;
    logic          b_init_busy;
    logic          b_ls_req = 1'b0, b_ls_we = 1'b0;
    logic [0:7]    b_ls_addr = '0;
    logic [0:DW-1] b_ls_wdata = '0;
    logic [0:LB-1] b_ls_bmask = '0;
    logic          b_ls_gnt, b_ls_rvalid;
    logic [0:DW-1] b_ls_rdata;
    logic          b_dma_req = 1'b0, b_dma_we = 1'b0;
    logic [0:7]    b_dma_addr = '0;
    logic [0:DW-1] b_dma_wdata = '0;
    logic          b_dma_gnt, b_dma_rvalid;
    logic [0:DW-1] b_dma_rdata;

    local_store_dp #(.ADDR_W(8), .LINE_BYTES(LB), .INIT_CLEAR(0), .STARVE_MAX(2)) dut_b (
        .clk(clk), .rst(b_rst), .init_busy(b_init_busy),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
        .ls_bmask(b_ls_bmask), .ls_gnt(b_ls_gnt), .ls_rdata(b_ls_rdata), .ls_rvalid(b_ls_rvalid),
        .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
        .dma_gnt(b_dma_gnt), .dma_rdata(b_dma_rdata), .dma_rvalid(b_dma_rvalid)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    logic [7:0] mdl [0:(1<<ADDR_W)-1];
    int busy_left = 0;
    int denials = 0;
    logic last_ls_gnt = 1'b0;

    typedef struct {
        int            cyc;
        logic [0:DW-1] data;
    } exp_t;
    exp_t lsq[$];
    exp_t dmaq[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [0:DW-1] act, input logic [0:DW-1] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int line_base(input logic [0:ADDR_W-1] a);
        return int'(a) & ~(LB - 1);
    endfunction

    function automatic logic [0:DW-1] model_read(input logic [0:ADDR_W-1] a);
        logic [0:DW-1] v;
        int base;
        base = line_base(a);
        for (int k = 0; k < LB; k++) v[8*k +: 8] = mdl[base + k];
        return v;
    endfunction

    task automatic model_write(input logic [0:ADDR_W-1] a, input logic [0:DW-1] d,
                               input logic [0:LB-1] m);
        int base;
        base = line_base(a);
        for (int k = 0; k < LB; k++) if (m[k]) mdl[base + k] = d[8*k +: 8];
    endtask

    // One cycle: inputs are already driven; predict, check grants, update model.
    task automatic tick(output logic lg, output logic dg);
        exp_t e;
        #1;
        lg = 1'b0;
        dg = 1'b0;
        if (!rst) begin
            chk1("init_busy", init_busy, busy_left > 0);
            if (busy_left == 0) begin
                lg = ls_req && (!dma_req || denials == SMAX);
                dg = dma_req && !lg;
            end
        end
        chk1("ls_gnt", ls_gnt, lg);
        chk1("dma_gnt", dma_gnt, dg);
        last_ls_gnt = ls_gnt;
        if (lg) begin
            if (ls_we) model_write(ls_addr, ls_wdata, ls_bmask);
            else begin
                e.cyc = cyc + 1; e.data = model_read(ls_addr); lsq.push_back(e);
            end
        end
        if (dg) begin
            if (dma_we) model_write(dma_addr, dma_wdata, '1);
            else begin
                e.cyc = cyc + 1; e.data = model_read(dma_addr); dmaq.push_back(e);
            end
        end
        if (rst || !ls_req || lg) denials = 0;
        else if (dg && denials < SMAX) denials++;
        if (rst) begin
            busy_left = NLINES;
            for (int i = 0; i < (1 << ADDR_W); i++) mdl[i] = 8'h00;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        @(negedge clk);
    endtask

    task automatic ls_op(input logic we, input int a, input logic [0:DW-1] d, input logic [0:LB-1] m);
        logic lg, dg;
        ls_req = 1'b1; ls_we = we; ls_addr = ADDR_W'(a); ls_wdata = d; ls_bmask = m;
        for (int i = 0; i < 8; i++) begin
            tick(lg, dg);
            if (lg) break;
        end
        ls_req = 1'b0;
    endtask

    task automatic dma_op(input logic we, input int a, input logic [0:DW-1] d);
        logic lg, dg;
        dma_req = 1'b1; dma_we = we; dma_addr = ADDR_W'(a); dma_wdata = d;
        for (int i = 0; i < 8; i++) begin
            tick(lg, dg);
            if (dg) break;
        end
        dma_req = 1'b0;
    endtask

    function automatic logic [0:ADDR_W-1] rand_addr();
        int line;
        line = int'($urandom_range(0, 7)) + (($urandom_range(0, 1) == 1) ? (NLINES - 8) : 0);
        return ADDR_W'((line << 4) | int'($urandom_range(0, 15)));
    endfunction

    function automatic logic [0:DW-1] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every rvalid must match the head of its port's queue, on time.
    always @(negedge clk) begin : mon
        exp_t e;
        if (ls_rvalid === 1'b1) begin
            if (lsq.size() == 0) chk1("ls_rvalid_unexpected", 1'b1, 1'b0);
            else begin
                e = lsq.pop_front();
                chkint("ls_rvalid_cycle", cyc, e.cyc);
                chkv("ls_rdata", ls_rdata, e.data);
            end
        end else if (lsq.size() > 0 && lsq[0].cyc <= cyc) begin
            e = lsq.pop_front();
            chk1("ls_rvalid_missing", 1'b0, 1'b1);
        end
        if (dma_rvalid === 1'b1) begin
            if (dmaq.size() == 0) chk1("dma_rvalid_unexpected", 1'b1, 1'b0);
            else begin
                e = dmaq.pop_front();
                chkint("dma_rvalid_cycle", cyc, e.cyc);
                chkv("dma_rdata", dma_rdata, e.data);
            end
        end else if (dmaq.size() > 0 && dmaq[0].cyc <= cyc) begin
            e = dmaq.pop_front();
            chk1("dma_rvalid_missing", 1'b0, 1'b1);
        end
    end

    initial begin : stim
        logic lg, dg;
        logic [0:DW-1] d;
        logic [0:LB-1] m;
        int ls_slot;
        lg = 1'b0; dg = 1'b0;
        @(negedge clk);

        // Reset and its register values.
        rst = 1'b1;
        tick(lg, dg);
        tick(lg, dg);
        chk1("rst_init_busy", init_busy, 1'b1);
        chk1("rst_ls_rvalid", ls_rvalid, 1'b0);
        chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
        chkv("rst_ls_rdata", ls_rdata, '0);
        chkv("rst_dma_rdata", dma_rdata, '0);
        rst = 1'b0;

        // Clear sequence: busy for exactly NLINES cycles (checked inside tick).
        repeat (NLINES) tick(lg, dg);
        ls_op(1'b0, 'h7FF0, '0, '0);

        // Full-line write, then masked overwrite via an unaligned address.
        for (int k = 0; k < LB; k++) d[8*k +: 8] = 8'(k);
        ls_op(1'b1, 'h0010, d, '1);
        m = '0; m[0] = 1'b1; m[15] = 1'b1;
        ls_op(1'b1, 'h0013, {16{8'hAA}}, m);
        ls_op(1'b0, 'h001F, '0, '0);

        // Starvation guard: both reading, LS must win on the fifth slot.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = ADDR_W'('h0010);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = ADDR_W'('h0100);
        ls_slot = -1;
        for (int i = 0; i < 7; i++) begin
            tick(lg, dg);
            if (last_ls_gnt && ls_slot < 0) ls_slot = i;
            if (lg) ls_req = 1'b0;
        end
        chkint("starve_ls_slot", ls_slot, SMAX);
        dma_req = 1'b0;

        // DMA write followed immediately by LS read of the same line.
        dma_op(1'b1, 'h0100, {16{8'h55}});
        ls_op(1'b0, 'h0100, '0, '0);
        tick(lg, dg);

        // Reset in RUN, then again mid-clear: written data must be gone.
        ls_op(1'b1, 'h0200, rand_data(), '1);
        dma_op(1'b0, 'h0200, '0);
        rst = 1'b1; tick(lg, dg); rst = 1'b0;
        repeat (1000) tick(lg, dg);
        rst = 1'b1; tick(lg, dg); rst = 1'b0;
        repeat (NLINES) tick(lg, dg);
        ls_op(1'b0, 'h0200, '0, '0);
        dma_op(1'b0, 'h0010, '0);

        // Randomised traffic, requests held until granted.
        lg = 1'b0; dg = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!ls_req || lg) begin
                ls_req = 1'($urandom_range(0, 1)); ls_we = 1'($urandom_range(0, 1));
                ls_addr = rand_addr(); ls_wdata = rand_data(); ls_bmask = LB'($urandom);
            end
            if (!dma_req || dg) begin
                dma_req = 1'($urandom_range(0, 1)); dma_we = 1'($urandom_range(0, 1));
                dma_addr = rand_addr(); dma_wdata = rand_data();
            end
            tick(lg, dg);
        end
        ls_req = 1'b0; dma_req = 1'b0;
        tick(lg, dg);
        tick(lg, dg);
        chkint("ls_queue_drained", lsq.size(), 0);
        chkint("dma_queue_drained", dmaq.size(), 0);

        // INIT_CLEAR=0 instance: never busy, DMA write / LS read round trip.
        chk1("b_busy_in_rst", b_init_busy, 1'b0);
        chkv("b_rst_rdata", b_ls_rdata, '0);
        d = rand_data();
        b_rst = 1'b0;
        b_dma_req = 1'b1; b_dma_we = 1'b1; b_dma_addr = 8'h30; b_dma_wdata = d;
        #1;
        chk1("b_init_busy", b_init_busy, 1'b0);
        chk1("b_dma_gnt", b_dma_gnt, 1'b1);
        chk1("b_ls_gnt_idle", b_ls_gnt, 1'b0);
        @(negedge clk);
        b_dma_req = 1'b0;
        b_ls_req = 1'b1; b_ls_we = 1'b0; b_ls_addr = 8'h3B;
        #1;
        chk1("b_ls_gnt", b_ls_gnt, 1'b1);
        @(negedge clk);
        b_ls_req = 1'b0;
        #1;
        chk1("b_ls_rvalid", b_ls_rvalid, 1'b1);
        chkv("b_ls_rdata", b_ls_rdata, d);
        chk1("b_dma_rvalid", b_dma_rvalid, 1'b0);
        chkv("b_dma_rdata", b_dma_rdata, '0);
        @(negedge clk);
        #1;
        chk1("b_ls_rvalid_pulse", b_ls_rvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
